// File: rtl/int_fixed_point_div_seq_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
// Shared constants, state encoding and helpers for the sequential
// integer / decimal-fixed-point divider (int_fixed_point_div_seq).
// A fixed-point value is fixed_X + fixed_Y/100000.
// -----------------------------------------------------------------------------
package fixed_point_pkg;

    localparam int INT_W  = 21;   // integer dividend / quotient width
    localparam int X_W    = 10;   // divisor integer part width
    localparam int Y_W    = 18;   // divisor fraction width (1e-5 units)
    localparam int NUM_W  = 37;   // |int_in| * FP_SCALE
    localparam int DEN_W  = 28;   // fixed_X * FP_SCALE + fixed_Y
    localparam int FRAC_W = 17;   // fraction digits 0..99999

    localparam logic [16:0] FP_SCALE = 17'd100000;
    localparam logic [20:0] INT_MAX  = 21'd1048575;

    // Step counter terminal values (count starts at 0)
    localparam logic [5:0] INT_LAST  = 6'd36;
    localparam logic [5:0] FRAC_LAST = 6'd16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        INT  = 3'd2,
        FRAC = 3'd3,
        FIN  = 3'd4
    } div_state_t;

    // Magnitude of a two's-complement divisor
    function automatic logic [DEN_W-1:0] den_magnitude(input logic [DEN_W-1:0] d);
        den_magnitude = d[DEN_W-1] ? (~d + 28'd1) : d;
    endfunction

endpackage

// File: rtl/int_fixed_point_div_seq_step.sv
// -----------------------------------------------------------------------------
// restoring_div_step
// One combinational restoring-division step: shift the partial remainder left
// by one bit, trial-subtract the divisor and emit the quotient bit.
// Ports:
//   rem_in  : partial remainder, always < den
//   bit_in  : next dividend bit (MSB first)
//   den     : divisor magnitude
//   rem_out : updated partial remainder, < den
//   q_bit   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module restoring_div_step
    import fixed_point_pkg::*;
(
    input  logic [DEN_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [DEN_W-1:0] den,
    output logic [DEN_W-1:0] rem_out,
    output logic             q_bit
);

    logic [DEN_W:0]   shifted_s;
    logic [DEN_W-1:0] diff_s;

    // Shift, trial subtract and restore
    always_comb begin
        shifted_s = {rem_in, bit_in};
        // True difference is < den, so the low DEN_W bits hold it exactly
        diff_s    = shifted_s[DEN_W-1:0] - den;
        if (shifted_s >= {1'b0, den}) begin
            q_bit   = 1'b1;
            rem_out = diff_s;
        end else begin
            q_bit   = 1'b0;
            rem_out = shifted_s[DEN_W-1:0];
        end
    end

endmodule

// File: rtl/int_fixed_point_div_seq.sv
// -----------------------------------------------------------------------------
// int_fixed_point_div_seq
// Serial signed divider: int_in / (fixed_X + fixed_Y/100000), one restoring
// step per clock. Returns a truncated, saturated integer quotient and, when
// the macro INT_FIXED_POINT_DIV_FRAC_EN is defined, a 5-digit decimal
// fraction (otherwise frac_out is 0 and latency is 39 cycles instead of 56).
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   start                 : request, sampled only in IDLE
//   int_in/fixed_X/fixed_Y: operands, captured in PREP
//   busy, done            : operation in progress / one-cycle result strobe
//   int_out, frac_out     : signed quotient, fraction magnitude
//   quot_neg, overflow,
//   div_zero              : result sign, saturation flag, zero divisor flag
// -----------------------------------------------------------------------------
module int_fixed_point_div_seq #(
    parameter int INT_W = 21,
    parameter int X_W   = 10,
    parameter int Y_W   = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [INT_W-1:0] int_in,
    input  logic [X_W-1:0]   fixed_X,
    input  logic [Y_W-1:0]   fixed_Y,
    output logic             busy,
    output logic             done,
    output logic [INT_W-1:0] int_out,
    output logic [16:0]      frac_out,
    output logic             quot_neg,
    output logic             overflow,
    output logic             div_zero
);
    import fixed_point_pkg::NUM_W;
    import fixed_point_pkg::DEN_W;
    import fixed_point_pkg::FRAC_W;
    import fixed_point_pkg::FP_SCALE;
    import fixed_point_pkg::INT_MAX;
    import fixed_point_pkg::INT_LAST;
    import fixed_point_pkg::FRAC_LAST;
    import fixed_point_pkg::div_state_t;
    import fixed_point_pkg::IDLE;
    import fixed_point_pkg::PREP;
    import fixed_point_pkg::INT;
    import fixed_point_pkg::FRAC;
    import fixed_point_pkg::FIN;
    import fixed_point_pkg::den_magnitude;

    div_state_t       state_r, state_n;
    logic [NUM_W-1:0] num_r;      // dividend shifted out MSB first; holds Q afterwards
    logic [DEN_W-1:0] den_r;
    logic [DEN_W-1:0] rem_r;
    logic [5:0]       cnt_r;
    logic             sign_r;     // sign(int_in) ^ sign(D)
    logic             in_neg_r;   // sign(int_in), used for zero divisor
    logic             dz_r;

    logic [DEN_W-1:0] x_ext_s, y_ext_s, den_s, den_mag_s;
    logic             den_zero_s;
    logic [INT_W-1:0] int_mag_s;
    logic [NUM_W-1:0] num_s;
    logic             step_bit_s, step_q_s;
    logic [DEN_W-1:0] step_rem_s;

    logic [FRAC_W-1:0] frac_s;
    logic              res_neg_s;
    logic [INT_W-1:0]  sat_pos_s, sat_neg_s, q_low_s;
    logic [INT_W-1:0]  fin_int_s;
    logic [FRAC_W-1:0] fin_frac_s;
    logic              fin_neg_s, fin_ovf_s;

`ifdef INT_FIXED_POINT_DIV_FRAC_EN
    logic [FRAC_W-1:0]       frac_sh_r;   // low dividend bits in, fraction bits out
    logic [DEN_W+FRAC_W-1:0] frac_seed_s; // R * FP_SCALE
`endif

    // Operand conditioning: signed divisor and scaled dividend magnitude
    always_comb begin
        x_ext_s    = {{(DEN_W-X_W){fixed_X[X_W-1]}}, fixed_X};
        y_ext_s    = {{(DEN_W-Y_W){fixed_Y[Y_W-1]}}, fixed_Y};
        den_s      = x_ext_s * DEN_W'(FP_SCALE) + y_ext_s;
        den_mag_s  = den_magnitude(den_s);
        den_zero_s = (den_s == {DEN_W{1'b0}});
        if (int_in[INT_W-1]) begin
            int_mag_s = ~int_in + INT_W'(1'b1);
        end else begin
            int_mag_s = int_in;
        end
        num_s = NUM_W'(int_mag_s) * NUM_W'(FP_SCALE);
    end

    // Select the dividend bit fed to the shared step
    always_comb begin
`ifdef INT_FIXED_POINT_DIV_FRAC_EN
        if (state_r == FRAC) begin
            step_bit_s = frac_sh_r[FRAC_W-1];
        end else begin
            step_bit_s = num_r[NUM_W-1];
        end
        // Since R < |D| and FP_SCALE < 2^17, R*FP_SCALE >> 17 is already < |D|:
        // it seeds the remainder so only 17 steps are needed.
        frac_seed_s = (DEN_W+FRAC_W)'(step_rem_s) * (DEN_W+FRAC_W)'(FP_SCALE);
`else
        step_bit_s = num_r[NUM_W-1];
`endif
    end

    restoring_div_step u_step (
        .rem_in  (rem_r),
        .bit_in  (step_bit_s),
        .den     (den_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Final sign, saturation and zero-divisor handling
    always_comb begin
`ifdef INT_FIXED_POINT_DIV_FRAC_EN
        frac_s = frac_sh_r;
`else
        frac_s = 17'd0;
`endif
        // A zero result is reported as non-negative
        res_neg_s  = sign_r & ~((num_r == {NUM_W{1'b0}}) & (frac_s == 17'd0));
        sat_pos_s  = INT_W'(INT_MAX);
        sat_neg_s  = ~sat_pos_s + INT_W'(1'b1);
        q_low_s    = num_r[INT_W-1:0];
        fin_int_s  = q_low_s;
        fin_frac_s = frac_s;
        fin_neg_s  = res_neg_s;
        fin_ovf_s  = 1'b0;
        if (dz_r) begin
            fin_int_s  = in_neg_r ? sat_neg_s : sat_pos_s;
            fin_frac_s = 17'd0;
            fin_neg_s  = in_neg_r;
        end else if (num_r > NUM_W'(INT_MAX)) begin
            fin_int_s  = res_neg_s ? sat_neg_s : sat_pos_s;
            fin_ovf_s  = 1'b1;
        end else begin
            fin_int_s  = res_neg_s ? (~q_low_s + INT_W'(1'b1)) : q_low_s;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_n = PREP;
                else       state_n = IDLE;
            end
            PREP: begin
                if (den_zero_s) state_n = FIN;
                else            state_n = INT;
            end
            INT: begin
                if (cnt_r == INT_LAST) begin
`ifdef INT_FIXED_POINT_DIV_FRAC_EN
                    state_n = FRAC;
`else
                    state_n = FIN;
`endif
                end else begin
                    state_n = INT;
                end
            end
`ifdef INT_FIXED_POINT_DIV_FRAC_EN
            FRAC: begin
                if (cnt_r == FRAC_LAST) state_n = FIN;
                else                    state_n = FRAC;
            end
`endif
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            num_r    <= {NUM_W{1'b0}};
            den_r    <= {DEN_W{1'b0}};
            rem_r    <= {DEN_W{1'b0}};
            cnt_r    <= 6'd0;
            sign_r   <= 1'b0;
            in_neg_r <= 1'b0;
            dz_r     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            int_out  <= {INT_W{1'b0}};
            frac_out <= 17'd0;
            quot_neg <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
`ifdef INT_FIXED_POINT_DIV_FRAC_EN
            frac_sh_r <= 17'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) busy <= 1'b1;
                end
                PREP: begin
                    num_r    <= num_s;
                    den_r    <= den_mag_s;
                    rem_r    <= {DEN_W{1'b0}};
                    cnt_r    <= 6'd0;
                    sign_r   <= int_in[INT_W-1] ^ den_s[DEN_W-1];
                    in_neg_r <= int_in[INT_W-1];
                    dz_r     <= den_zero_s;
                end
                INT: begin
                    rem_r <= step_rem_s;
                    num_r <= {num_r[NUM_W-2:0], step_q_s};
                    cnt_r <= cnt_r + 6'd1;
`ifdef INT_FIXED_POINT_DIV_FRAC_EN
                    if (cnt_r == INT_LAST) begin
                        rem_r     <= frac_seed_s[DEN_W+FRAC_W-1:FRAC_W];
                        frac_sh_r <= frac_seed_s[FRAC_W-1:0];
                        cnt_r     <= 6'd0;
                    end
`endif
                end
`ifdef INT_FIXED_POINT_DIV_FRAC_EN
                FRAC: begin
                    rem_r     <= step_rem_s;
                    frac_sh_r <= {frac_sh_r[FRAC_W-2:0], step_q_s};
                    cnt_r     <= cnt_r + 6'd1;
                end
`endif
                FIN: begin
                    int_out  <= fin_int_s;
                    frac_out <= fin_frac_s;
                    quot_neg <= fin_neg_s;
                    overflow <= fin_ovf_s;
                    div_zero <= dz_r;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
